pc_stack_counter: RTL and testbench
===================================

Name: pc_stack_counter

Overview:
- Parametrised program counter for the RISC core, the next generation of the 8-bit PC.
- Supports these next-PC modes: hold, increment, absolute jump, PC-relative branch, subroutine call and subroutine return.
- Calls and returns use a return-address stack of configurable depth.
- Sits between the control FSM, which drives the mode strobes, and instruction memory, which is addressed by out; jump and branch targets come from the datapath C bus.

Parameters:
- PC_WIDTH, 8: width of the program counter and of each stack entry.
- DATA_WIDTH, 16: width of the C bus; must be >= PC_WIDTH.
- STACK_DEPTH, 4: number of return-address entries; must be >= 1.
- RESET_VECTOR, 0: value loaded into the PC on reset.

Ports:
- clk  in  1  rising-edge clock.
- reset  in  1  synchronous, active-high reset.
- stall  in  1  freezes all state for this cycle.
- loadpc  in  1  increment: PC <= PC+1.
- msel  in  1  absolute jump: PC <= C[PC_WIDTH-1:0].
- brel  in  1  relative branch: PC <= PC + C[PC_WIDTH-1:0], offset is two's complement.
- call  in  1  push PC+1, then PC <= C[PC_WIDTH-1:0].
- ret  in  1  PC <= popped return address.
- C  in  DATA_WIDTH  datapath bus carrying the target or offset.
- out  out  PC_WIDTH  current program counter.
- depth  out  $clog2(STACK_DEPTH+1)  number of valid stack entries.
- stack_full  out  1  depth == STACK_DEPTH.
- stack_empty  out  1  depth == 0.
- err  out  1  sticky stack overflow/underflow flag.

Behaviour:
- All state updates on the rising edge of clk. out is a register; there is no combinational path from any input to out.
  - A command sampled at edge N is visible on out after edge N.
- Reset, synchronous and active-high: out=RESET_VECTOR, depth=0, err=0, stack_empty=1, stack_full=0.
  - Stack contents need not be cleared.
  - Reset overrides every other input, including a call or ret in progress.
- Priority, highest first: reset > stall > ret > call > msel > brel > loadpc > hold.
  - Only the highest asserted command executes; lower ones are ignored that cycle.
- stall=1: out, depth, stack contents and err all hold.
- Arithmetic is modulo 2^PC_WIDTH; C bits above PC_WIDTH-1 are ignored.
  - Increment wraps: with PC_WIDTH=8, 8'hFF -> 8'h00.
  - brel: out + C[PC_WIDTH-1:0], truncated. For example, out=8'h05 with C[7:0]=8'hFE gives 8'h03.
- call, not full:
  - stack[depth] <= out+1 (wrapped); depth <= depth+1; out <= C[PC_WIDTH-1:0].
- call when full:
  - out still jumps to the target.
  - The return address is discarded; depth and stack contents are unchanged; err <= 1.
- ret, not empty: out <= stack[depth-1]; depth <= depth-1.
- ret when empty: out holds, depth stays 0, err <= 1.
- Stack is strict LIFO; only call and ret change depth.
- stack_full and stack_empty are decoded combinationally from the depth register.
- err is set only by overflow or underflow and cleared only by reset.
- No command asserted and no stall: out holds.

Test Plan:
- Reset then increment: reset=1 for 1 cycle, then loadpc=1 for 3 cycles -> out 0,1,2,3; depth=0, stack_empty=1, err=0. Repeat from out=8'hFF with loadpc -> 8'h00.
- Jump and branch: msel=1, C=16'hAB40 -> out=8'h40. Then brel=1, C[7:0]=8'hFC -> out=8'h3C. Then brel with 8'h10 -> out=8'h4C.
- Nested call/return: from out=8'h10, call to 8'h80, then call to 8'hC0 -> depth=2. Then ret -> out=8'h81, depth=1. Then ret -> out=8'h11, depth=0, err=0.
- Overflow and underflow: 5 calls with STACK_DEPTH=4 -> 5th call jumps, depth stays 4, stack_full=1, err=1. Pop 4 times and check the first 4 return addresses in LIFO order. A 5th ret holds out, depth=0, err stays 1.
- Priority and stall: ret+call+msel asserted together with depth=1 -> only the pop occurs. stall=1 with call=1 -> out, depth and err unchanged.
- Reset mid-operation: depth=3 and call=1 in the same cycle as reset=1 -> out=RESET_VECTOR, depth=0, err=0. A following ret -> err=1 and out holds.

Source files
------------

// File: rtl/pc_stack_counter.sv
// ============================================================================
//  Module      : pc_stack_counter
//  Description : Program counter with hold, increment, jump, relative branch,
//                and call/return through a return-address stack.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module pc_stack_counter #(
    parameter int          PC_WIDTH     = 8,
    parameter int          DATA_WIDTH   = 16,
    parameter int          STACK_DEPTH  = 4,
    parameter int unsigned RESET_VECTOR = 0
) (
    input  logic                             clk,
    input  logic                             reset,
    input  logic                             stall,
    input  logic                             loadpc,
    input  logic                             msel,
    input  logic                             brel,
    input  logic                             call,
    input  logic                             ret,
    input  logic [DATA_WIDTH-1:0]            C,
    output logic [PC_WIDTH-1:0]              out,
    output logic [$clog2(STACK_DEPTH+1)-1:0] depth,
    output logic                             stack_full,
    output logic                             stack_empty,
    output logic                             err
);

    localparam int c_DEPTH_W = $clog2(STACK_DEPTH + 1);
    localparam int c_IDX_W   = (STACK_DEPTH > 1) ? $clog2(STACK_DEPTH) : 1;

    logic [PC_WIDTH-1:0]  r_pc;
    logic [c_DEPTH_W-1:0] r_depth;
    logic                 r_err;
    logic [PC_WIDTH-1:0]  r_stack [STACK_DEPTH];

    logic [PC_WIDTH-1:0]  w_target;
    logic [PC_WIDTH-1:0]  w_pc_inc;
    logic [c_DEPTH_W-1:0] w_depth_m1;
    logic [c_IDX_W-1:0]   w_push_idx;
    logic [c_IDX_W-1:0]   w_pop_idx;
    logic                 w_full;
    logic                 w_empty;

    assign w_target   = C[PC_WIDTH-1:0];
    assign w_pc_inc   = r_pc + PC_WIDTH'(1);
    assign w_depth_m1 = r_depth - c_DEPTH_W'(1);
    // Only the low bits are needed: indices are always below STACK_DEPTH when used.
    assign w_push_idx = r_depth[c_IDX_W-1:0];
    assign w_pop_idx  = w_depth_m1[c_IDX_W-1:0];
    assign w_full     = (r_depth == c_DEPTH_W'(STACK_DEPTH));
    assign w_empty    = (r_depth == '0);

    generate
        if (DATA_WIDTH > PC_WIDTH) begin : g_c_hi
            logic w_unused_c_hi;
            assign w_unused_c_hi = ^C[DATA_WIDTH-1:PC_WIDTH];
        end
    endgenerate

    always_ff @(posedge clk) begin
        if (reset) begin
            r_pc    <= PC_WIDTH'(RESET_VECTOR);
            r_depth <= '0;
            r_err   <= 1'b0;
        end else if (!stall) begin
            if (ret) begin
                if (w_empty) begin
                    r_err <= 1'b1;
                end else begin
                    r_pc    <= r_stack[w_pop_idx];
                    r_depth <= w_depth_m1;
                end
            end else if (call) begin
                // The jump happens even on overflow; only the return address is lost.
                r_pc <= w_target;
                if (w_full) begin
                    r_err <= 1'b1;
                end else begin
                    r_stack[w_push_idx] <= w_pc_inc;
                    r_depth             <= r_depth + c_DEPTH_W'(1);
                end
            end else if (msel) begin
                r_pc <= w_target;
            end else if (brel) begin
                r_pc <= r_pc + w_target;
            end else if (loadpc) begin
                r_pc <= w_pc_inc;
            end
        end
    end

    assign out         = r_pc;
    assign depth       = r_depth;
    assign stack_full  = w_full;
    assign stack_empty = w_empty;
    assign err         = r_err;

endmodule

`default_nettype wire

// File: tb/tb_pc_stack_counter.sv
// ============================================================================
//  Module      : tb_pc_stack_counter
//  Description : Self-checking bench for pc_stack_counter (default parameters).
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_pc_stack_counter;

    localparam int PW = 8;
    localparam int SD = 4;
    localparam int RV = 0;

    logic        clk;
    logic        reset, stall, loadpc, msel, brel, call, ret;
    logic [15:0] C;
    logic [7:0]  out;
    logic [2:0]  depth;
    logic        stack_full, stack_empty, err;

    int total = 0;
    int bad   = 0;

    pc_stack_counter #(
        .PC_WIDTH    (PW),
        .DATA_WIDTH  (16),
        .STACK_DEPTH (SD),
        .RESET_VECTOR(RV)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .stall      (stall),
        .loadpc     (loadpc),
        .msel       (msel),
        .brel       (brel),
        .call       (call),
        .ret        (ret),
        .C          (C),
        .out        (out),
        .depth      (depth),
        .stack_full (stack_full),
        .stack_empty(stack_empty),
        .err        (err)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Reference model: PC as an integer mod 2^PW, the stack as a queue.
    int m_pc;
    int m_stk[$];
    bit m_err;
    bit m_valid = 1'b0;

    always @(posedge clk) begin
        if (reset) begin
            m_pc = RV;
            m_stk.delete();
            m_err   = 1'b0;
            m_valid = 1'b1;
        end else if (!stall) begin
            if (ret) begin
                if (m_stk.size() == 0) m_err = 1'b1;
                else m_pc = m_stk.pop_back();
            end else if (call) begin
                if (m_stk.size() < SD) m_stk.push_back((m_pc + 1) % 256);
                else m_err = 1'b1;
                m_pc = C % 256;
            end else if (msel) begin
                m_pc = C % 256;
            end else if (brel) begin
                m_pc = (m_pc + (C % 256)) % 256;
            end else if (loadpc) begin
                m_pc = (m_pc + 1) % 256;
            end
        end
    end

    always @(negedge clk) begin
        if (m_valid) begin
            total++;
            if (int'(out) != m_pc || int'(depth) != m_stk.size() || err != m_err ||
                stack_full != (m_stk.size() == SD) || stack_empty != (m_stk.size() == 0)) begin
                bad++;
                $display("FAIL model t=%0t out=%h depth=%0d err=%b full=%b empty=%b required out=%h depth=%0d err=%b",
                         $time, out, depth, err, stack_full, stack_empty, m_pc[7:0], m_stk.size(), m_err);
            end
        end
    end

    task automatic lit(input string name, input int act, input int exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s got=%0h required=%0h", name, act, exp);
        end
    endtask

    // Applies one command for exactly one rising edge, then returns at the next falling edge.
    task automatic cmd(input logic rs, input logic st, input logic lp, input logic ms,
                       input logic br, input logic ca, input logic rt, input logic [15:0] cv);
        reset = rs; stall = st; loadpc = lp; msel = ms;
        brel = br; call = ca; ret = rt; C = cv;
        @(negedge clk);
        reset = 0; stall = 0; loadpc = 0; msel = 0;
        brel = 0; call = 0; ret = 0; C = 16'h0;
    endtask

    task automatic do_reset();            cmd(1,0,0,0,0,0,0,16'h0); endtask
    task automatic do_inc();              cmd(0,0,1,0,0,0,0,16'h0); endtask
    task automatic do_jmp(input logic [15:0] c); cmd(0,0,0,1,0,0,0,c); endtask
    task automatic do_br(input logic [15:0] c);  cmd(0,0,0,0,1,0,0,c); endtask
    task automatic do_call(input logic [15:0] c); cmd(0,0,0,0,0,1,0,c); endtask
    task automatic do_ret();              cmd(0,0,0,0,0,0,1,16'h0); endtask

    initial begin
        int exp_ra[4];
        exp_ra = '{8'h41, 8'h31, 8'h21, 8'h12};

        // Reset and increment
        do_reset();
        lit("rst_out", out, 0);
        lit("rst_depth", depth, 0);
        lit("rst_empty", stack_empty, 1);
        lit("rst_full", stack_full, 0);
        lit("rst_err", err, 0);
        for (int i = 1; i <= 3; i++) begin
            do_inc();
            lit("inc_out", out, i);
        end
        do_jmp(16'h00FF);
        do_inc();
        lit("inc_wrap", out, 8'h00);

        // Jump and branch
        do_jmp(16'hAB40);
        lit("jmp", out, 8'h40);
        do_br(16'h00FC);
        lit("br_neg", out, 8'h3C);
        do_br(16'h0010);
        lit("br_pos", out, 8'h4C);
        do_jmp(16'h0005);
        do_br(16'h12FE);
        lit("br_ex", out, 8'h03);

        // Nested call / return
        do_jmp(16'h0010);
        do_call(16'h0080);
        do_call(16'h00C0);
        lit("call2_out", out, 8'hC0);
        lit("call2_depth", depth, 2);
        do_ret();
        lit("ret1_out", out, 8'h81);
        lit("ret1_depth", depth, 1);
        do_ret();
        lit("ret2_out", out, 8'h11);
        lit("ret2_depth", depth, 0);
        lit("ret2_err", err, 0);

        // Overflow then underflow
        do_call(16'h0020);
        do_call(16'h0030);
        do_call(16'h0040);
        do_call(16'h0050);
        lit("full_err", err, 0);
        do_call(16'h0060);
        lit("ovf_out", out, 8'h60);
        lit("ovf_depth", depth, 4);
        lit("ovf_full", stack_full, 1);
        lit("ovf_err", err, 1);
        for (int i = 0; i < 4; i++) begin
            do_ret();
            lit("lifo_ra", out, exp_ra[i]);
        end
        do_ret();
        lit("unf_out", out, 8'h12);
        lit("unf_depth", depth, 0);
        lit("unf_err", err, 1);

        // Priority and stall
        do_reset();
        do_jmp(16'h0010);
        do_call(16'h0050);
        cmd(0,0,0,1,0,1,1,16'h0099);
        lit("prio_out", out, 8'h11);
        lit("prio_depth", depth, 0);
        lit("prio_err", err, 0);
        do_call(16'h0030);
        cmd(0,1,0,0,0,1,0,16'h0077);
        lit("stall_out", out, 8'h30);
        lit("stall_depth", depth, 1);
        lit("stall_err", err, 0);
        cmd(0,1,1,0,0,0,0,16'h0);
        lit("stall_inc", out, 8'h30);

        // Reset mid-operation
        do_call(16'h0040);
        do_call(16'h0050);
        lit("pre_rst_depth", depth, 3);
        cmd(1,0,0,0,0,1,0,16'h0088);
        lit("mid_rst_out", out, RV);
        lit("mid_rst_depth", depth, 0);
        lit("mid_rst_err", err, 0);
        do_ret();
        lit("post_rst_err", err, 1);
        lit("post_rst_out", out, RV);

        @(negedge clk);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

`default_nettype wire
